// File: rtl/alu_accumulator_ctrl_pkg.sv
// Shared opcode constants and sequencing states for the accumulator controller.
package alu_pkg;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_accumulator_ctrl_alu.sv
// Combinational ALU: arithmetic reports wrap through carry_out (add) or borrow (subtract).
module alu #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic [3:0]           opcode,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity
);

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_ADDC = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_INC  = 4'd4;
  localparam logic [3:0] ALU_DEC  = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_NOT  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_ROR  = 4'd9;

  localparam logic [BUS_WIDTH:0] ONE = {{BUS_WIDTH{1'b0}}, 1'b1};

  logic [BUS_WIDTH:0] ext_a;
  logic [BUS_WIDTH:0] ext_b;
  logic [BUS_WIDTH:0] sum;

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};

  always_comb begin
    sum       = '0;
    y         = '0;
    carry_out = 1'b0;
    borrow    = 1'b0;
    case (opcode)
      ALU_ADD: begin
        sum       = ext_a + ext_b;
        y         = sum[BUS_WIDTH-1:0];
        carry_out = sum[BUS_WIDTH];
      end
      ALU_ADDC: begin
        sum       = ext_a + ext_b + {{BUS_WIDTH{1'b0}}, carry_in};
        y         = sum[BUS_WIDTH-1:0];
        carry_out = sum[BUS_WIDTH];
      end
      ALU_SUB: begin
        sum    = ext_a - ext_b;
        y      = sum[BUS_WIDTH-1:0];
        borrow = sum[BUS_WIDTH];
      end
      ALU_INC: begin
        sum       = ext_a + ONE;
        y         = sum[BUS_WIDTH-1:0];
        carry_out = sum[BUS_WIDTH];
      end
      ALU_DEC: begin
        sum    = ext_a - ONE;
        y      = sum[BUS_WIDTH-1:0];
        borrow = sum[BUS_WIDTH];
      end
      ALU_AND: y = a & b;
      ALU_NOT: y = ~a;
      ALU_ROL: y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
      ALU_ROR: y = {a[0], a[BUS_WIDTH-1:1]};
      default: y = '0;
    endcase
  end

  assign zero   = ~|y;
  assign parity = ^y;

endmodule

// File: rtl/alu_accumulator_ctrl.sv
// Accumulator sequencer: command in, ALU evaluates for one cycle, result held until taken.
module alu_accumulator_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_opcode,
  input  logic [BUS_WIDTH-1:0] cmd_operand,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BUS_WIDTH-1:0] res_data,
  output logic                 res_carry,
  output logic                 res_zero,
  output logic                 res_parity,
  output logic                 res_err,
  output logic [BUS_WIDTH-1:0] acc_out,
  output logic                 err_sticky
);

  state_t state_q, state_d;

  logic [3:0]           op_q;
  logic [BUS_WIDTH-1:0] operand_q;
  logic [BUS_WIDTH-1:0] acc_q;
  logic                 carry_q;
  logic                 err_sticky_q;
  logic [BUS_WIDTH-1:0] res_data_q;
  logic                 res_carry_q, res_zero_q, res_parity_q, res_err_q;

  logic [BUS_WIDTH-1:0] alu_y;
  logic                 alu_carry, alu_borrow, alu_zero, alu_parity;

  logic [BUS_WIDTH-1:0] wb_acc;
  logic                 wb_carry, wb_zero, wb_parity, wb_err;

  alu #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
    .a         (acc_q),
    .b         (operand_q),
    .carry_in  (carry_q),
    .opcode    (op_q),
    .y         (alu_y),
    .carry_out (alu_carry),
    .borrow    (alu_borrow),
    .zero      (alu_zero),
    .parity    (alu_parity)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == HOLD);
  end

  // Invalid opcodes fall through with acc/carry untouched, flags taken from the old acc.
  always_comb begin
    wb_acc    = acc_q;
    wb_carry  = carry_q;
    wb_zero   = ~|acc_q;
    wb_parity = ^acc_q;
    wb_err    = 1'b0;
    if (op_q == OP_LOAD) begin
      wb_acc    = operand_q;
      wb_zero   = ~|operand_q;
      wb_parity = ^operand_q;
    end else if (op_q <= OP_ROR) begin
      wb_acc    = alu_y;
      wb_zero   = alu_zero;
      wb_parity = alu_parity;
      if (op_q <= OP_DEC) wb_carry = alu_carry | alu_borrow;
    end else begin
      wb_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_LOAD;
      operand_q    <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      err_sticky_q <= 1'b0;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      res_zero_q   <= 1'b0;
      res_parity_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        op_q      <= cmd_opcode;
        operand_q <= cmd_operand;
      end
      if (state_q == EXEC) begin
        acc_q        <= wb_acc;
        carry_q      <= wb_carry;
        err_sticky_q <= err_sticky_q | wb_err;
        res_data_q   <= wb_acc;
        res_carry_q  <= wb_carry;
        res_zero_q   <= wb_zero;
        res_parity_q <= wb_parity;
        res_err_q    <= wb_err;
      end
    end
  end

  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_zero   = res_zero_q;
  assign res_parity = res_parity_q;
  assign res_err    = res_err_q;
  assign acc_out    = acc_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_alu_accumulator_ctrl.sv
// Bench for alu_accumulator_ctrl: directed table, handshake corner cases, random vs. arithmetic model.
module tb_alu_accumulator_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode = '0;
  logic [W-1:0] cmd_operand = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_carry, res_zero, res_parity, res_err;
  logic [W-1:0] acc_out;
  logic         err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_accumulator_ctrl #(.BUS_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_operand (cmd_operand),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_carry   (res_carry),
    .res_zero    (res_zero),
    .res_parity  (res_parity),
    .res_err     (res_err),
    .acc_out     (acc_out),
    .err_sticky  (err_sticky)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
    logic         parity;
    logic         err;
  } res_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] operand;
    res_t         exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic over the command semantics.
  function automatic res_t model(input int op, input int opnd, input int acc, input int cy);
    res_t r;
    int   y;
    int   c;
    logic [W-1:0] v;
    y = acc;
    c = cy;
    r.err = 1'b0;
    case (op)
      0: y = opnd;
      1: begin y = (acc + opnd) % 256;      c = (acc + opnd > 255) ? 1 : 0; end
      2: begin y = (acc + opnd + cy) % 256; c = (acc + opnd + cy > 255) ? 1 : 0; end
      3: begin y = (acc - opnd + 256) % 256; c = (acc < opnd) ? 1 : 0; end
      4: begin y = (acc + 1) % 256;         c = (acc == 255) ? 1 : 0; end
      5: begin y = (acc + 255) % 256;       c = (acc == 0) ? 1 : 0; end
      6: y = acc & opnd;
      7: y = 255 - acc;
      8: y = (acc * 2) % 256 + acc / 128;
      9: y = acc / 2 + (acc % 2) * 128;
      default: r.err = 1'b1;
    endcase
    v        = y[W-1:0];
    r.data   = v;
    r.carry  = c[0];
    r.zero   = (y == 0);
    r.parity = ($countones(v) % 2) == 1;
    return r;
  endfunction

  // Full transaction: accept, check one-cycle EXEC, capture, stall 'hold' cycles, handshake.
  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] opnd,
                         input int unsigned hold, output res_t got);
    int unsigned n;
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_operand = opnd;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("exec_res_valid", {31'd0, res_valid}, 32'd0);
    tick();
    check("latency_res_valid", {31'd0, res_valid}, 32'd1);
    got.data   = res_data;
    got.carry  = res_carry;
    got.zero   = res_zero;
    got.parity = res_parity;
    got.err    = res_err;
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check("hold_stable", {23'd0, res_valid, res_data}, {23'd0, 1'b1, got.data});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("handshake_drop", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic compare_res(input string tag, input res_t got, input res_t exp);
    check({tag, "_data"},   {24'd0, got.data},   {24'd0, exp.data});
    check({tag, "_carry"},  {31'd0, got.carry},  {31'd0, exp.carry});
    check({tag, "_zero"},   {31'd0, got.zero},   {31'd0, exp.zero});
    check({tag, "_parity"}, {31'd0, got.parity}, {31'd0, exp.parity});
    check({tag, "_err"},    {31'd0, got.err},    {31'd0, exp.err});
    check({tag, "_acc"},    {24'd0, acc_out},    {24'd0, exp.data});
  endtask

  initial begin
    vec_t vecs[15];
    res_t got;
    res_t exp;
    int   m_acc;
    int   m_cy;
    logic m_sticky;

    //               op     operand        data   c     z     p     err
    vecs[0]  = '{4'd0, 8'h7F, '{8'h7F, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{4'd0, 8'hFF, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{4'd2, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{4'd2, 8'h00, '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{4'd0, 8'h00, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[5]  = '{4'd5, 8'h00, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{4'd8, 8'h00, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{4'd0, 8'h5A, '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{4'd12, 8'h33, '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[9]  = '{4'd1, 8'h01, '{8'h5B, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{4'd3, 8'h60, '{8'hFB, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{4'd7, 8'h00, '{8'h04, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[12] = '{4'd4, 8'h00, '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[13] = '{4'd9, 8'h00, '{8'h82, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[14] = '{4'd6, 8'h0F, '{8'h02, 1'b0, 1'b0, 1'b1, 1'b0}};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_res_valid",  {31'd0, res_valid},  32'd0);
    check("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
    check("rst_acc",        {24'd0, acc_out},    32'd0);
    check("rst_res_data",   {24'd0, res_data},   32'd0);
    check("rst_flags",      {28'd0, res_carry, res_zero, res_parity, res_err}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_cmd(vecs[i].op, vecs[i].operand, 0, got);
      compare_res($sformatf("vec%0d", i), got, vecs[i].exp);
      if (i == 8) check("sticky_set", {31'd0, err_sticky}, 32'd1);
    end
    check("sticky_kept", {31'd0, err_sticky}, 32'd1);

    // Backpressure: result held 5 cycles while a new command waits.
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_operand = 8'h33;
    tick();
    cmd_operand = 8'h44;
    tick();
    check("bp_valid", {31'd0, res_valid}, 32'd1);
    check("bp_data",  {24'd0, res_data},  32'h33);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {22'd0, res_valid, cmd_ready, res_data}, {22'd0, 1'b1, 1'b0, 8'h33});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_release", {30'd0, res_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    tick();
    cmd_valid = 1'b0;
    check("bp_next_accept", {30'd0, res_valid, cmd_ready}, 32'd0);
    tick();
    check("bp_next_valid", {31'd0, res_valid}, 32'd1);
    check("bp_next_data",  {24'd0, res_data},  32'h44);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset while a command sits in EXEC.
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_operand = 8'h99;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", {30'd0, res_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    check("midrst_acc",   {24'd0, acc_out}, 32'd0);
    check("midrst_sticky", {31'd0, err_sticky}, 32'd0);
    repeat (3) tick();
    check("midrst_no_result", {23'd0, res_valid, acc_out}, 32'd0);

    // Random commands from reset state, judged by the arithmetic model.
    m_acc = 0;
    m_cy = 0;
    m_sticky = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int op;
      int opnd;
      op   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      opnd = int'($urandom_range(0, 255));
      exp  = model(op, opnd, m_acc, m_cy);
      run_cmd(op[3:0], opnd[7:0], $urandom_range(0, 2), got);
      compare_res($sformatf("rnd%0d_op%0d", i, op), got, exp);
      m_acc = int'(exp.data);
      m_cy  = int'(exp.carry);
      m_sticky |= exp.err;
      check("rnd_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
